// File: rtl/mem_bus_ctrl.sv
// Memory-stage bus controller: sequences strobes for two external SRAMs and the UART,
// stalls the pipeline while an access is in flight and registers read results.
module mem_bus_ctrl #(
  parameter int          RAM_ADDR_W     = 18,
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  is_RAM1_i,
  input  logic                  is_UART_i,
  input  logic                  is_RAM2_i,
  input  logic                  memread_i,
  input  logic                  memwrite_i,
  input  logic [15:0]           addr_i,
  input  logic [15:0]           wdata_i,
  output logic                  ram1_en_o,
  output logic                  ram1_oe_o,
  output logic                  ram1_we_o,
  output logic [RAM_ADDR_W-1:0] ram1_addr_o,
  inout  wire  [15:0]           ram1_data_io,
  output logic                  ram2_en_o,
  output logic                  ram2_oe_o,
  output logic                  ram2_we_o,
  output logic [RAM_ADDR_W-1:0] ram2_addr_o,
  inout  wire  [15:0]           ram2_data_io,
  output logic                  rdn_o,
  output logic                  wrn_o,
  input  logic                  data_ready_i,
  input  logic                  tbre_i,
  input  logic                  tsre_i,
  output logic [15:0]           mem1_res_o,
  output logic [15:0]           mem2_res_o,
  output logic                  stall_o
);
  typedef enum logic [2:0] {S_IDLE, S_ACC1, S_ACC2, S_ACC3, S_DONE} state_t;
  localparam logic [1:0] T_RAM1 = 2'd0, T_UDAT = 2'd1, T_USTA = 2'd2, T_RAM2 = 2'd3;

  state_t      r_state, w_next;
  logic [1:0]  r_tgt, w_tgt;
  logic        r_wr;
  logic [15:0] r_addr, r_wdata, r_res1, r_res2;
  logic        w_req, w_acc, w_rdwin, w_wpulse, w_drv1, w_drv2;

  assign w_req = (memread_i | memwrite_i) & (is_RAM1_i | is_UART_i | is_RAM2_i);

  // Any UART address other than the data register takes the strobe-less path.
  always_comb begin
    w_tgt = T_RAM1;
    if (is_RAM2_i)      w_tgt = T_RAM2;
    else if (is_UART_i) w_tgt = (addr_i == UART_DATA_ADDR) ? T_UDAT : T_USTA;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_next = (w_tgt == T_USTA) ? S_DONE : S_ACC1;
      S_ACC1:  w_next = S_ACC2;
      S_ACC2:  w_next = r_wr ? S_ACC3 : S_DONE;
      S_ACC3:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_acc     = (r_state == S_ACC1) | (r_state == S_ACC2) | (r_state == S_ACC3);
    w_rdwin   = ~r_wr & ((r_state == S_ACC1) | (r_state == S_ACC2));
    w_wpulse  = r_wr & (r_state == S_ACC2);
    ram1_en_o = ~((r_tgt == T_RAM1) & w_acc);
    ram1_oe_o = ~((r_tgt == T_RAM1) & w_rdwin);
    ram1_we_o = ~((r_tgt == T_RAM1) & w_wpulse);
    ram2_en_o = ~((r_tgt == T_RAM2) & w_acc);
    ram2_oe_o = ~((r_tgt == T_RAM2) & w_rdwin);
    ram2_we_o = ~((r_tgt == T_RAM2) & w_wpulse);
    rdn_o     = ~((r_tgt == T_UDAT) & w_rdwin);
    wrn_o     = ~((r_tgt == T_UDAT) & w_wpulse);
    // Data spans ACC1..ACC3 so it brackets the one-cycle write pulse.
    w_drv1    = r_wr & w_acc & ((r_tgt == T_RAM1) | (r_tgt == T_UDAT));
    w_drv2    = r_wr & w_acc & (r_tgt == T_RAM2);
    stall_o   = ~rst & (((r_state == S_IDLE) & w_req) | w_acc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tgt   <= T_RAM1;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_res1  <= '0;
      r_res2  <= '0;
    end else begin
      if (r_state == S_IDLE && w_req) begin
        r_tgt   <= w_tgt;
        r_wr    <= memwrite_i;
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
        if (w_tgt == T_USTA && !memwrite_i && addr_i == UART_STAT_ADDR)
          r_res1 <= {14'b0, data_ready_i, tbre_i & tsre_i};
      end
      if (r_state == S_ACC2 && !r_wr) begin
        if (r_tgt == T_RAM2) r_res2 <= ram2_data_io;
        else                 r_res1 <= ram1_data_io;
      end
    end
  end

  assign ram1_data_io = w_drv1 ? r_wdata : 16'hzzzz;
  assign ram2_data_io = w_drv2 ? r_wdata : 16'hzzzz;
  assign ram1_addr_o  = {{(RAM_ADDR_W-16){1'b0}}, r_addr};
  assign ram2_addr_o  = {{(RAM_ADDR_W-16){1'b0}}, r_addr};
  assign mem1_res_o   = r_res1;
  assign mem2_res_o   = r_res2;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: SRAM/UART device models plus a per-cycle expectation queue
// derived from each access's cycle schedule, checked on every falling edge.
module tb_mem_bus_ctrl;
  logic clk = 1'b1, rst = 1'b1;
  logic is_RAM1_i = 0, is_UART_i = 0, is_RAM2_i = 0, memread_i = 0, memwrite_i = 0;
  logic [15:0] addr_i = 0, wdata_i = 0;
  logic data_ready_i = 0, tbre_i = 0, tsre_i = 0;
  logic ram1_en_o, ram1_oe_o, ram1_we_o, ram2_en_o, ram2_oe_o, ram2_we_o, rdn_o, wrn_o, stall_o;
  logic [17:0] ram1_addr_o, ram2_addr_o;
  logic [15:0] mem1_res_o, mem2_res_o;
  wire  [15:0] ram1_data_io, ram2_data_io;

  mem_bus_ctrl dut (
    .clk(clk), .rst(rst), .is_RAM1_i(is_RAM1_i), .is_UART_i(is_UART_i), .is_RAM2_i(is_RAM2_i),
    .memread_i(memread_i), .memwrite_i(memwrite_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .ram1_en_o(ram1_en_o), .ram1_oe_o(ram1_oe_o), .ram1_we_o(ram1_we_o), .ram1_addr_o(ram1_addr_o),
    .ram1_data_io(ram1_data_io), .ram2_en_o(ram2_en_o), .ram2_oe_o(ram2_oe_o), .ram2_we_o(ram2_we_o),
    .ram2_addr_o(ram2_addr_o), .ram2_data_io(ram2_data_io), .rdn_o(rdn_o), .wrn_o(wrn_o),
    .data_ready_i(data_ready_i), .tbre_i(tbre_i), .tsre_i(tsre_i),
    .mem1_res_o(mem1_res_o), .mem2_res_o(mem2_res_o), .stall_o(stall_o));

  always #5 clk = ~clk;

  // Device models: SRAMs and UART receive register.
  localparam logic [15:0] UART_Q = 16'h005A;
  logic [15:0] dev1 [0:65535];
  logic [15:0] dev2 [0:65535];
  logic [15:0] uart_tx = 0;
  int stall_tot = 0;
  assign ram1_data_io = (!ram1_en_o && !ram1_oe_o) ? dev1[ram1_addr_o[15:0]] :
                        (!rdn_o ? UART_Q : 16'hzzzz);
  assign ram2_data_io = (!ram2_en_o && !ram2_oe_o) ? dev2[ram2_addr_o[15:0]] : 16'hzzzz;
  always @(negedge clk) begin
    if (!ram1_en_o && !ram1_we_o) dev1[ram1_addr_o[15:0]] <= ram1_data_io;
    if (!ram2_en_o && !ram2_we_o) dev2[ram2_addr_o[15:0]] <= ram2_data_io;
    if (!wrn_o) uart_tx <= ram1_data_io;
    if (stall_o) stall_tot <= stall_tot + 1;
  end

  // Model state
  typedef struct {
    logic stall, e1, o1, w1, e2, o2, w2, rdn, wrn;
    logic [15:0] b1, b2, res1, res2;
    logic [17:0] a;
  } rec_t;
  rec_t q[$];
  logic [15:0] sb1 [0:65535];
  logic [15:0] sb2 [0:65535];
  logic [15:0] m_res1 = 0, m_res2 = 0;
  logic [17:0] m_addr = 0;
  int c_tgt, c_L;  // target: 0 RAM1, 1 UART data, 2 UART other, 3 RAM2; c_L = DONE cycle index
  logic c_wr;
  logic [15:0] c_a, c_wd;
  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic rec_t mk_idle();
    rec_t r;
    r.stall = 0; r.e1 = 1; r.o1 = 1; r.w1 = 1; r.e2 = 1; r.o2 = 1; r.w2 = 1; r.rdn = 1; r.wrn = 1;
    r.b1 = 16'hzzzz; r.b2 = 16'hzzzz; r.res1 = m_res1; r.res2 = m_res2; r.a = m_addr;
    return r;
  endfunction

  // Expected outputs for cycle k of the current access (k=0 is the request cycle).
  task automatic step(input int k);
    rec_t r;
    logic act, rdw, wp, drv;
    if (k == 1) m_addr = {2'b00, c_a};
    if (k == c_L) begin
      if (!c_wr) begin
        case (c_tgt)
          0: m_res1 = sb1[c_a];
          1: m_res1 = UART_Q;
          2: if (c_a == 16'hBF01) m_res1 = {14'b0, data_ready_i, tbre_i & tsre_i};
          default: m_res2 = sb2[c_a];
        endcase
      end else if (c_tgt == 0) sb1[c_a] = c_wd;
      else if (c_tgt == 3) sb2[c_a] = c_wd;
    end
    r = mk_idle();
    r.stall = (k < c_L);
    act = (k >= 1) && (k < c_L);
    rdw = !c_wr && (k == 1 || k == 2) && c_tgt != 2;
    wp  = c_wr && k == 2 && c_tgt != 2;
    drv = c_wr && act;
    case (c_tgt)
      0: begin r.e1 = !act; r.o1 = !rdw; r.w1 = !wp;
               r.b1 = drv ? c_wd : (rdw ? sb1[c_a] : 16'hzzzz); end
      1: begin r.rdn = !rdw; r.wrn = !wp;
               r.b1 = drv ? c_wd : (rdw ? UART_Q : 16'hzzzz); end
      3: begin r.e2 = !act; r.o2 = !rdw; r.w2 = !wp;
               r.b2 = drv ? c_wd : (rdw ? sb2[c_a] : 16'hzzzz); end
      default: ;
    endcase
    q.push_back(r);
  endtask

  always @(negedge clk) begin
    rec_t r;
    if (q.size() > 0) begin
      r = q.pop_front();
      chk("stall", {17'b0, stall_o}, {17'b0, r.stall});
      chk("ram1_en", {17'b0, ram1_en_o}, {17'b0, r.e1});
      chk("ram1_oe", {17'b0, ram1_oe_o}, {17'b0, r.o1});
      chk("ram1_we", {17'b0, ram1_we_o}, {17'b0, r.w1});
      chk("ram2_en", {17'b0, ram2_en_o}, {17'b0, r.e2});
      chk("ram2_oe", {17'b0, ram2_oe_o}, {17'b0, r.o2});
      chk("ram2_we", {17'b0, ram2_we_o}, {17'b0, r.w2});
      chk("rdn", {17'b0, rdn_o}, {17'b0, r.rdn});
      chk("wrn", {17'b0, wrn_o}, {17'b0, r.wrn});
      chk("bus1", {2'b0, ram1_data_io}, {2'b0, r.b1});
      chk("bus2", {2'b0, ram2_data_io}, {2'b0, r.b2});
      chk("mem1_res", {2'b0, mem1_res_o}, {2'b0, r.res1});
      chk("mem2_res", {2'b0, mem2_res_o}, {2'b0, r.res2});
      chk("ram1_addr", ram1_addr_o, r.a);
      chk("ram2_addr", ram2_addr_o, r.a);
    end
  end

  task automatic drive(input logic s1, su, s2, rd, wr, input logic [15:0] a, wd);
    is_RAM1_i = s1; is_UART_i = su; is_RAM2_i = s2;
    memread_i = rd; memwrite_i = wr; addr_i = a; wdata_i = wd;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
    q.push_back(mk_idle());
  endtask

  // Inputs are held through DONE like a stalled pipeline; abort_k asserts rst at that cycle.
  int s0;
  task automatic access(input logic s1, su, s2, rd, wr, input logic [15:0] a, wd,
                        input int abort_k);
    c_tgt = s2 ? 3 : (su ? ((a == 16'hBF00) ? 1 : 2) : 0);
    c_wr  = wr;
    c_L   = (c_tgt == 2) ? 1 : (wr ? 4 : 3);
    c_a   = a; c_wd = wd;
    for (int k = 0; k <= c_L; k++) begin
      @(posedge clk); #1;
      if (k == abort_k) begin
        rst = 1;
        drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
        m_res1 = 0; m_res2 = 0; m_addr = 0;
        q.push_back(mk_idle());
        return;
      end
      if (k == 0) begin
        drive(s1, su, s2, rd, wr, a, wd);
        s0 = stall_tot;
      end
      step(k);
    end
  endtask

  task automatic pin_done();
    @(negedge clk); #1;
  endtask

  initial begin
    dev1[16'hC000] = 16'hBEEF; sb1[16'hC000] = 16'hBEEF;
    q.push_back(mk_idle());
    @(posedge clk); #1; rst = 0; q.push_back(mk_idle());
    idle();
    // RAM2 write then read back
    access(0, 0, 1, 0, 1, 16'h0040, 16'h1234, -1);
    pin_done(); chk("stall_cycles_wr", 18'(stall_tot - s0), 18'd4);
    idle();
    access(0, 0, 1, 1, 0, 16'h0040, 16'h0000, -1);
    pin_done();
    chk("pin_mem2_res", {2'b0, mem2_res_o}, 18'h01234);
    chk("pin_ram2_addr", ram2_addr_o, 18'h00040);
    chk("stall_cycles_rd", 18'(stall_tot - s0), 18'd3);
    // back-to-back: RAM1 write then read, each starting the cycle after DONE
    access(1, 0, 0, 0, 1, 16'h0100, 16'h5555, -1);
    access(1, 0, 0, 1, 0, 16'h0100, 16'h0000, -1);
    idle();
    access(1, 0, 0, 1, 0, 16'hC000, 16'h0000, -1);
    pin_done(); chk("pin_mem1_beef", {2'b0, mem1_res_o}, 18'h0BEEF);
    // UART data write and read
    access(0, 1, 0, 0, 1, 16'hBF00, 16'h0041, -1);
    pin_done(); chk("pin_uart_tx", {2'b0, uart_tx}, 18'h00041);
    access(0, 1, 0, 1, 0, 16'hBF00, 16'h0000, -1);
    idle();
    // UART status read and ignored status write
    data_ready_i = 1; tbre_i = 1; tsre_i = 0;
    access(0, 1, 0, 1, 0, 16'hBF01, 16'h0000, -1);
    pin_done();
    chk("pin_status", {2'b0, mem1_res_o}, 18'h00002);
    chk("stall_cycles_stat", 18'(stall_tot - s0), 18'd1);
    access(0, 1, 0, 0, 1, 16'hBF01, 16'hFFFF, -1);
    idle();
    // priority RAM2 over RAM1; simultaneous read+write is a write
    access(1, 0, 1, 1, 0, 16'h0040, 16'h0000, -1);
    access(0, 0, 1, 1, 1, 16'h0050, 16'h7777, -1);
    access(0, 0, 1, 1, 0, 16'h0050, 16'h0000, -1);
    pin_done(); chk("pin_rdwr_is_wr", {2'b0, mem2_res_o}, 18'h07777);
    // reset in ACC2 of a RAM1 write
    access(1, 0, 0, 0, 1, 16'h9000, 16'hA5A5, 2);
    pin_done();
    chk("pin_rst_we", {17'b0, ram1_we_o}, 18'd1);
    chk("pin_rst_res1", {2'b0, mem1_res_o}, 18'h0);
    @(posedge clk); #1; rst = 0; q.push_back(mk_idle());
    access(0, 0, 1, 1, 0, 16'h0040, 16'h0000, -1);
    idle(); idle();
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Downstream of the MEM-stage address decoder in the 16-bit CPU. It takes the decoded select lines (RAM1 / UART / RAM2), the address, write data and read/write requests, and runs the multi-cycle strobe sequences for the two external SRAMs and the on-board UART. It stalls the pipeline while an access is in flight and returns read data on mem1_res_o and mem2_res_o, which the decoder muxes into its memory-result output.

Parameters:
RAM_ADDR_W, 18, external SRAM address width; the CPU address is zero-extended to this width.
UART_DATA_ADDR, 16'hBF00, UART data register address.
UART_STAT_ADDR, 16'hBF01, UART status register address.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
is_RAM1_i  input  1  decoder select: RAM1 (extended memory)
is_UART_i  input  1  decoder select: UART data or status
is_RAM2_i  input  1  decoder select: RAM2 (data memory)
memread_i  input  1  load request
memwrite_i  input  1  store request
addr_i  input  16  access address (ALU result)
wdata_i  input  16  store data
ram1_en_o / ram1_oe_o / ram1_we_o  output  1 each  RAM1 chip enable, output enable, write enable (all active-low)
ram1_addr_o  output  RAM_ADDR_W  RAM1 address
ram1_data_io  inout  16  RAM1 data bus, shared with the UART
ram2_en_o / ram2_oe_o / ram2_we_o  output  1 each  RAM2 controls (all active-low)
ram2_addr_o  output  RAM_ADDR_W  RAM2 address
ram2_data_io  inout  16  RAM2 data bus
rdn_o / wrn_o  output  1 each  UART read and write strobes (active-low)
data_ready_i, tbre_i, tsre_i  input  1 each  UART status flags
mem1_res_o  output  16  RAM1/UART read result
mem2_res_o  output  16  RAM2 read result
stall_o  output  1  hold the pipeline while high

Behaviour:
- Reset (asynchronous, immediate, including mid-access):
  - state goes to IDLE.
  - All en/oe/we/rdn/wrn outputs are driven 1.
  - Both data buses are high-Z.
  - Addresses, mem1_res_o, mem2_res_o and stall_o are 0.
- Request: in IDLE, req = (memread_i | memwrite_i) & (is_RAM1_i | is_UART_i | is_RAM2_i).
  - On the cycle req is seen, the block latches the target, direction, address and write data.
  - Target priority: RAM2 > UART > RAM1.
  - If memread_i and memwrite_i are both high, the access is a write.
- States: IDLE, ACC1, ACC2, ACC3, DONE.
- stall_o = (IDLE & req) | ACC1 | ACC2 | ACC3, computed combinationally. It is low in DONE, so the pipeline advances at the end of DONE. DONE always returns to IDLE and never re-samples the select lines.
- RAM read: IDLE -> ACC1 -> ACC2 -> DONE.
  - en and oe are low during ACC1 and ACC2.
  - The bus is captured into the result register at the end of ACC2.
  - Cycles stalled: 3.
- RAM write: IDLE -> ACC1 -> ACC2 -> ACC3 -> DONE.
  - en is low during ACC1 through ACC3; we is low only in ACC2.
  - Data is driven during ACC1 through ACC3, giving setup and hold around the we pulse.
- UART data read (UART_DATA_ADDR): IDLE -> ACC1 -> ACC2 -> DONE.
  - rdn is low during ACC1 and ACC2; data is captured at the end of ACC2.
  - ram1_en_o stays 1 throughout, so the UART owns the shared bus.
- UART write: same timing as a RAM write, with wrn in place of we. Data is driven on ram1_data_io; ram1_en_o stays 1.
- UART status read (UART_STAT_ADDR): IDLE -> DONE.
  - No strobes are issued.
  - mem1_res_o is set to {14'b0, data_ready_i, tbre_i & tsre_i}, sampled in the IDLE cycle.
  - A status write is ignored: it passes through IDLE -> DONE with no strobe.
- Address outputs: ram*_addr_o = zero-extended latched address, held from ACC1 through DONE.
- Results: mem1_res_o and mem2_res_o hold their last captured value until the next read of the same target.
- Bus ownership: the block never drives a data bus while any oe or rdn on that bus is low. The bus is high-Z outside write states.

Test Plan:
- rst pulse during ACC2 of a RAM1 write at 16'h9000 -> ram1_we_o is 1 and ram1_data_io is high-Z in the same cycle; state is IDLE; mem1_res_o is 0.
- Write 16'h1234 to 16'h0040, then read it back (RAM2 model) -> ram2_we_o is low only in ACC2; ram2_addr_o is 18'h00040; stall is high for 4 cycles and then 3 cycles; mem2_res_o is 16'h1234 in DONE.
- Read RAM1 at 16'hC000 with the model returning 16'hBEEF -> ram1_oe_o is low for 2 cycles; mem1_res_o is 16'hBEEF; ram2_en_o stays 1.
- UART write of 16'h0041 to 16'hBF00 -> wrn_o is low for 1 cycle with data stable in ACC1 through ACC3; ram1_en_o stays 1.
- Read 16'hBF01 with data_ready_i=1, tbre_i=1, tsre_i=0 -> 1-cycle stall; mem1_res_o is 16'h0002; no strobes are issued.
- Back-to-back requests: a read followed by a write presented in the cycle after DONE -> the second access starts cleanly from IDLE with no duplicate strobe from the first request.
